// File: rtl/idecode_if.sv
// idecode_if - bundle of the fetch/execute/writeback signals around the
// instruction-decode stage.
//   slave  modport : the decode stage (consumes inst/flush/ex/wb, drives
//                    stall_o and the ID/EX register contents)
//   master modport : the surrounding pipeline (or a testbench)
// Signals:
//   inst_i, inst_addr_i            instruction word and its address from ifetch
//   flush_i                        taken branch/jump, kill younger instructions
//   ex_stall_i, ex_load_i, ex_rd_i execute-stage status for stalling/hazards
//   wb_we_i, wb_addr_i, wb_data_i  register-file writeback port
//   stall_o                        hold request back to ifetch
//   valid_o .. illegal_o           ID/EX register contents
interface idecode_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [31:0]       inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              flush_i;
    logic              ex_stall_i;
    logic              ex_load_i;
    logic [4:0]        ex_rd_i;
    logic              wb_we_i;
    logic [4:0]        wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              stall_o;
    logic              valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [5:0]        opcode_o;
    logic [4:0]        rd_o;
    logic              we_o;
    logic              is_load_o;
    logic              is_store_o;
    logic              is_branch_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic              illegal_o;

    modport slave (
        input  inst_i, inst_addr_i, flush_i, ex_stall_i, ex_load_i, ex_rd_i,
               wb_we_i, wb_addr_i, wb_data_i,
        output stall_o, valid_o, pc_o, opcode_o, rd_o, we_o, is_load_o,
               is_store_o, is_branch_o, rs_data_o, rt_data_o, imm_o, illegal_o
    );

    modport master (
        output inst_i, inst_addr_i, flush_i, ex_stall_i, ex_load_i, ex_rd_i,
               wb_we_i, wb_addr_i, wb_data_i,
        input  stall_o, valid_o, pc_o, opcode_o, rd_o, we_o, is_load_o,
               is_store_o, is_branch_o, rs_data_o, rt_data_o, imm_o, illegal_o
    );
endinterface

// File: rtl/idecode.sv
// idecode - instruction decode stage.
// Holds the IF/ID register, a 32-entry register file with write-through
// read ports, load-use hazard detection and the ID/EX output register.
// Ports:
//   clk  single clock, all state updates on posedge
//   rst  synchronous active-high reset
//   bus  idecode_if.slave (see idecode_if.sv for the signal list)
module idecode #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    idecode_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [5:0]        opcode;
        logic [4:0]        rd;
        logic              we;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } idex_t;

    // IF/ID register
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;

    // ID/EX register
    idex_t             idex_q, idex_d, dec_s;

    // Register file
    logic [DATA_W-1:0] rf_q [32];

    // Decode helpers
    logic [5:0]        opc_s;
    logic [4:0]        rd_f_s, rs_f_s, rt_f_s;
    logic              reads_rs_s, reads_rt_s, writes_s;
    logic              is_load_s, is_store_s, is_branch_s, illegal_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s;
    logic              hazard_s, stall_s;

    assign opc_s  = ir_q[31:26];
    assign rd_f_s = ir_q[25:21];
    assign rs_f_s = ir_q[20:16];
    assign rt_f_s = ir_q[15:11];

    // Opcode classification: which sources are read, whether rd is written.
    always_comb begin
        reads_rs_s  = 1'b0;
        reads_rt_s  = 1'b0;
        writes_s    = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        is_branch_s = 1'b0;
        illegal_s   = 1'b0;
        case (opc_s)
            6'h00: begin reads_rs_s = 1'b1; reads_rt_s = 1'b1; writes_s = 1'b1; end
            6'h01: begin reads_rs_s = 1'b1; writes_s = 1'b1; end
            6'h02: begin reads_rs_s = 1'b1; writes_s = 1'b1; is_load_s = 1'b1; end
            6'h03: begin reads_rs_s = 1'b1; reads_rt_s = 1'b1; is_store_s = 1'b1; end
            6'h04: begin reads_rs_s = 1'b1; reads_rt_s = 1'b1; is_branch_s = 1'b1; end
            6'h05: begin end
            6'h3F: begin end
            default: illegal_s = 1'b1;
        endcase
    end

    // Register-file read ports; a same-cycle writeback to the index bypasses the array.
    always_comb begin
        if (rs_f_s == 5'd0) begin
            rs_val_s = '0;
        end else if (bus.wb_we_i && (bus.wb_addr_i == rs_f_s)) begin
            rs_val_s = bus.wb_data_i;
        end else begin
            rs_val_s = rf_q[rs_f_s];
        end
        if (rt_f_s == 5'd0) begin
            rt_val_s = '0;
        end else if (bus.wb_we_i && (bus.wb_addr_i == rt_f_s)) begin
            rt_val_s = bus.wb_data_i;
        end else begin
            rt_val_s = rf_q[rt_f_s];
        end
    end

    // Full decode of the instruction sitting in the IF/ID register.
    always_comb begin
        dec_s           = '0;
        dec_s.valid     = 1'b1;
        dec_s.pc        = ir_pc_q;
        dec_s.opcode    = opc_s;
        dec_s.rd        = rd_f_s;
        dec_s.we        = writes_s && (rd_f_s != 5'd0);
        dec_s.is_load   = is_load_s;
        dec_s.is_store  = is_store_s;
        dec_s.is_branch = is_branch_s;
        dec_s.rs_data   = rs_val_s;
        dec_s.rt_data   = rt_val_s;
        dec_s.imm       = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
        dec_s.illegal   = illegal_s;
    end

    // Load-use hazard and the hold request back to ifetch; flush and reset win.
    always_comb begin
        hazard_s = ir_valid_q && bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                   ((reads_rs_s && (bus.ex_rd_i == rs_f_s)) ||
                    (reads_rt_s && (bus.ex_rd_i == rt_f_s)));
        stall_s  = !rst && !bus.flush_i && (bus.ex_stall_i || hazard_s);
    end

    assign bus.stall_o = stall_s;

    // Next state of IF/ID and ID/EX. Execute stall is a full hold (no bubble),
    // a hazard holds IF/ID and inserts a bubble into ID/EX.
    always_comb begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        idex_d     = idex_q;
        if (bus.flush_i) begin
            ir_valid_d = 1'b0;
            idex_d     = '0;
        end else if (bus.ex_stall_i) begin
            idex_d     = idex_q;
        end else if (hazard_s) begin
            idex_d     = '0;
        end else begin
            ir_d       = bus.inst_i;
            ir_pc_d    = bus.inst_addr_i;
            ir_valid_d = 1'b1;
            idex_d     = ir_valid_q ? dec_s : '0;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            idex_q     <= '0;
        end else begin
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            idex_q     <= idex_d;
        end
    end

    // Register-file write port; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wb_we_i && (bus.wb_addr_i != 5'd0)) begin
            rf_q[bus.wb_addr_i] <= bus.wb_data_i;
        end else begin
            rf_q[0] <= '0;
        end
    end

    assign bus.valid_o     = idex_q.valid;
    assign bus.pc_o        = idex_q.pc;
    assign bus.opcode_o    = idex_q.opcode;
    assign bus.rd_o        = idex_q.rd;
    assign bus.we_o        = idex_q.we;
    assign bus.is_load_o   = idex_q.is_load;
    assign bus.is_store_o  = idex_q.is_store;
    assign bus.is_branch_o = idex_q.is_branch;
    assign bus.rs_data_o   = idex_q.rs_data;
    assign bus.rt_data_o   = idex_q.rt_data;
    assign bus.imm_o       = idex_q.imm;
    assign bus.illegal_o   = idex_q.illegal;

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 Parameter: ADDR_W, 16, instruction address width.
REQ-002 Parameter: DATA_W, 32, instruction and register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 inst_i  input  32  instruction word from ifetch.
REQ-006 inst_addr_i  input  ADDR_W  address of inst_i from ifetch.
REQ-007 flush_i  input  1  taken branch/jump from execute; kill younger instructions.
REQ-008 ex_stall_i  input  1  execute cannot accept a new instruction.
REQ-009 ex_load_i  input  1  instruction currently in execute is a LOAD.
REQ-010 ex_rd_i  input  5  destination register of the instruction in execute.
REQ-011 wb_we_i  input  1  writeback enable.
REQ-012 wb_addr_i  input  5  writeback register index.
REQ-013 wb_data_i  input  DATA_W  writeback data.
REQ-014 stall_o  output  1  hold request to ifetch (drives ifetch stall_i).
REQ-015 valid_o, pc_o[ADDR_W], opcode_o[6], rd_o[5], we_o, is_load_o, is_store_o, is_branch_o, rs_data_o[DATA_W], rt_data_o[DATA_W], imm_o[DATA_W], illegal_o  outputs  ID/EX register contents.

Function
REQ-016 Fields: opcode=inst[31:26], rd=inst[25:21], rs=inst[20:16], rt=inst[15:11], imm=inst[15:0] sign-extended to DATA_W.
REQ-017 Opcodes: 00 ALU-reg (reads rs,rt; writes rd); 01 ALU-imm (reads rs; writes rd); 02 LOAD (reads rs; writes rd); 03 STORE (reads rs,rt); 04 BRANCH (reads rs,rt); 05 JUMP (no reads); 3F NOP; any other opcode = illegal.
REQ-018 Illegal opcode: emitted with valid_o=1, illegal_o=1, we_o=0, all is_* flags 0.
REQ-019 we_o=1 only for opcodes 00/01/02 with rd!=0.
REQ-020 IF/ID register (ir, ir_pc, ir_valid) captures inst_i/inst_addr_i on every edge unless held; ir_valid set to 1 on the first capture after reset.
REQ-021 ID/EX output register loads the decode of ir on every edge unless held.
REQ-022 Latency: inst_i present in cycle N appears on outputs in cycle N+2 when no stall/flush.
REQ-023 Register file: 32 x DATA_W, two combinational read ports (rs, rt), one write port; x0 reads 0; writes to x0 ignored.
REQ-024 Write-through: wb_we_i=1 with wb_addr_i==rs (or rt), index!=0, in the same cycle -> read returns wb_data_i.
REQ-025 Load-use hazard: ir_valid & ex_load_i & ex_rd_i!=0 & ex_rd_i equals an index the ir instruction reads -> stall_o=1, IF/ID holds, ID/EX loads a bubble (valid_o=0, we_o=0, all flags 0).
REQ-026 ex_stall_i=1 -> stall_o=1; IF/ID and ID/EX both hold their contents unchanged.
REQ-027 flush_i=1 -> next edge: ir_valid=0 and valid_o=0; flush overrides ex_stall_i and hazard; stall_o=0 during flush.
REQ-028 Hazard and ex_stall_i together -> behave as ex_stall_i (full hold, no bubble inserted).
REQ-029 ir_valid=0 -> ID/EX loads a bubble; no hazard raised.
REQ-030 stall_o is combinational from current state and inputs, valid in the same cycle.

Reset
REQ-031 rst=1 at a posedge: ir_valid=0, ir=0, ir_pc=0, all ID/EX outputs 0, all 32 registers 0.
REQ-032 stall_o=0 while rst=1; reset overrides flush, stall and writeback in the same cycle.
REQ-033 Reset asserted mid-stall: next cycle all outputs 0 and stall_o=0.

Verification
REQ-034 ALU-reg 0x00A21800 (rd=5, rs=2, rt=3) at cycle N, regs x2=7, x3=9 -> cycle N+2: valid_o=1, rd_o=5, we_o=1, rs_data_o=7, rt_data_o=9, pc_o=inst_addr_i.
REQ-035 Load-use: EX holds LOAD to x4 (ex_load_i=1, ex_rd_i=4), ir=ALU-reg reading x4 -> stall_o=1 for one cycle, one bubble (valid_o=0), then the instruction issues.
REQ-036 Write-through: wb_we_i=1, wb_addr_i=2, wb_data_i=0xDEADBEEF while ir reads rs=2 -> rs_data_o=0xDEADBEEF next cycle.
REQ-037 flush_i=1 together with ex_stall_i=1 -> next cycle valid_o=0 and stall_o=0; write to x0 with 0x1234 -> x0 still reads 0.
REQ-038 Illegal opcode 0x2A and imm=0x8001 -> illegal_o=1, we_o=0, imm_o=0xFFFF8001.
REQ-039 rst=1 for one cycle during ex_stall_i=1 -> all outputs 0, stall_o=0; first instruction after reset emerges two cycles later.
